vme_bus_arbiter: RTL and testbench

VME_BUS_ARBITER -- requirements
Module: vme_bus_arbiter

---
 rtl/vme_arb_pkg.sv | 14 +
 rtl/vme_arb_req_latch.sv | 37 +++
 rtl/vme_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_arb_pkg.sv
// Shared types and widths for the two-port VME register-bus arbiter.
package vme_arb_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
  } slot_t;
endpackage

// File: rtl/vme_arb_req_latch.sv
// One requester's pending slot: captures a strobe, holds it until that port's done.
module vme_arb_req_latch
  import vme_arb_pkg::*;
(
  input  logic              Clk,
  input  logic              rst_n,
  input  logic [ADDR_W:1]   addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic              clr,
  output logic              pending,
  output slot_t             slot,
  output logic              overrun
);
  logic strobe, take;

  // A strobe landing on the completing edge refills the slot instead of overrunning.
  assign strobe = rd_mem | wr_mem;
  assign take   = strobe && (!pending || clr);

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      slot    <= '0;
      overrun <= 1'b0;
    end else begin
      if (take) begin
        pending <= 1'b1;
        slot    <= '{addr: addr, data: wr_data, wr: wr_mem};
      end else if (clr) begin
        pending <= 1'b0;
      end
      if ((strobe && !take) || (rd_mem && wr_mem)) overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/vme_bus_arbiter.sv
// Round-robin arbiter muxing two requesters onto one register-bus master, with timeout.
module vme_bus_arbiter
  import vme_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 16'hDEAD
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic [ADDR_W:1]   a_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic              a_rd_mem,
  input  logic              a_wr_mem,
  output logic [DATA_W-1:0] a_rd_data,
  output logic              a_rd_done,
  output logic              a_wr_done,
  output logic              a_err,
  output logic              a_overrun,
  input  logic [ADDR_W:1]   b_addr,
  input  logic [DATA_W-1:0] b_wr_data,
  input  logic              b_rd_mem,
  input  logic              b_wr_mem,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              b_rd_done,
  output logic              b_wr_done,
  output logic              b_err,
  output logic              b_overrun,
  output logic [ADDR_W:1]   m_addr,
  output logic [DATA_W-1:0] m_wr_data,
  output logic              m_rd_mem,
  output logic              m_wr_mem,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_rd_done,
  input  logic              m_wr_done,
  output logic              busy
);
  state_t   state;
  port_id_t gnt;
  logic     gnt_wr;
  logic [7:0] tcnt;

  logic     a_pend, b_pend, a_clr, b_clr;
  slot_t    a_slot, b_slot, pick_slot;
  port_id_t pick;
  logic     accept, tmo, finish;

  vme_arb_req_latch u_lat_a (
    .Clk(Clk), .rst_n(rst_n), .addr(a_addr), .wr_data(a_wr_data),
    .rd_mem(a_rd_mem), .wr_mem(a_wr_mem), .clr(a_clr),
    .pending(a_pend), .slot(a_slot), .overrun(a_overrun)
  );

  vme_arb_req_latch u_lat_b (
    .Clk(Clk), .rst_n(rst_n), .addr(b_addr), .wr_data(b_wr_data),
    .rd_mem(b_rd_mem), .wr_mem(b_wr_mem), .clr(b_clr),
    .pending(b_pend), .slot(b_slot), .overrun(b_overrun)
  );

  // gnt doubles as last-grant: B wins only if A is idle or A went last.
  assign pick      = (b_pend && (!a_pend || gnt == PORT_A)) ? PORT_B : PORT_A;
  assign pick_slot = (pick == PORT_B) ? b_slot : a_slot;
  assign accept    = (state == ST_ISSUE || state == ST_WAIT) && (gnt_wr ? m_wr_done : m_rd_done);
  assign tmo       = (state == ST_WAIT) && (tcnt == 8'(TIMEOUT_CYCLES - 1));
  assign finish    = accept || tmo;
  assign a_clr     = finish && (gnt == PORT_A);
  assign b_clr     = finish && (gnt == PORT_B);

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= PORT_B;
      gnt_wr    <= 1'b0;
      tcnt      <= '0;
      busy      <= 1'b0;
      m_rd_mem  <= 1'b0;
      m_wr_mem  <= 1'b0;
      m_addr    <= '0;
      m_wr_data <= '0;
      a_rd_done <= 1'b0;
      a_wr_done <= 1'b0;
      a_err     <= 1'b0;
      a_rd_data <= '0;
      b_rd_done <= 1'b0;
      b_wr_done <= 1'b0;
      b_err     <= 1'b0;
      b_rd_data <= '0;
    end else begin
      a_rd_done <= 1'b0;
      a_wr_done <= 1'b0;
      a_err     <= 1'b0;
      b_rd_done <= 1'b0;
      b_wr_done <= 1'b0;
      b_err     <= 1'b0;
      m_rd_mem  <= 1'b0;
      m_wr_mem  <= 1'b0;
      case (state)
        ST_IDLE: if (a_pend || b_pend) begin
          state     <= ST_ISSUE;
          busy      <= 1'b1;
          gnt       <= pick;
          gnt_wr    <= pick_slot.wr;
          m_addr    <= pick_slot.addr;
          m_wr_data <= pick_slot.data;
          m_rd_mem  <= !pick_slot.wr;
          m_wr_mem  <= pick_slot.wr;
        end
        ST_ISSUE: begin
          tcnt <= '0;
          if (accept) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: if (finish) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (finish) begin
        if (gnt == PORT_A) begin
          a_rd_done <= !gnt_wr;
          a_wr_done <= gnt_wr;
          a_err     <= !accept;
          if (!gnt_wr) a_rd_data <= accept ? m_rd_data : TIMEOUT_DATA;
        end else begin
          b_rd_done <= !gnt_wr;
          b_wr_done <= gnt_wr;
          b_err     <= !accept;
          if (!gnt_wr) b_rd_data <= accept ? m_rd_data : TIMEOUT_DATA;
        end
      end
    end
  end
endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Scoreboard bench: expected issues/completions queued at stimulus, checked as the DUT emits them.
module tb_vme_bus_arbiter;
  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:1] a_addr = '0, b_addr = '0, m_addr;
  logic [15:0] a_wr_data = '0, b_wr_data = '0, m_wr_data;
  logic        a_rd_mem = 1'b0, a_wr_mem = 1'b0, b_rd_mem = 1'b0, b_wr_mem = 1'b0;
  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_done, a_wr_done, a_err, a_overrun;
  logic        b_rd_done, b_wr_done, b_err, b_overrun;
  logic        m_rd_mem, m_wr_mem, busy;
  logic [15:0] m_rd_data = '0;
  logic        m_rd_done, m_wr_done;
  logic        slv_rd_done = 1'b0, slv_wr_done = 1'b0, man_rd_done = 1'b0;

  assign m_rd_done = slv_rd_done | man_rd_done;
  assign m_wr_done = slv_wr_done;

  always #5 Clk = ~Clk;

  vme_bus_arbiter #(.TIMEOUT_CYCLES(64), .TIMEOUT_DATA(16'hDEAD)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .a_addr(a_addr), .a_wr_data(a_wr_data), .a_rd_mem(a_rd_mem), .a_wr_mem(a_wr_mem),
    .a_rd_data(a_rd_data), .a_rd_done(a_rd_done), .a_wr_done(a_wr_done),
    .a_err(a_err), .a_overrun(a_overrun),
    .b_addr(b_addr), .b_wr_data(b_wr_data), .b_rd_mem(b_rd_mem), .b_wr_mem(b_wr_mem),
    .b_rd_data(b_rd_data), .b_rd_done(b_rd_done), .b_wr_done(b_wr_done),
    .b_err(b_err), .b_overrun(b_overrun),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_mem(m_rd_mem), .m_wr_mem(m_wr_mem),
    .m_rd_data(m_rd_data), .m_rd_done(m_rd_done), .m_wr_done(m_wr_done),
    .busy(busy)
  );

  typedef struct {logic port; logic rd; logic [15:0] data; logic err; int cyc;} done_t;
  typedef struct {logic wr; logic [19:1] addr; logic [15:0] data;} iss_t;

  done_t exp_done[$];
  iss_t  exp_iss[$];
  int tests = 0, fails = 0, cyc = 0;
  int slv_en = 1, slv_dly = 1, pend_rsp = 0, dcnt = 0;
  logic pend_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Slave model: answers slv_dly cycles after the strobe (0 = inside the strobe cycle).
  always @(negedge Clk) begin
    iss_t ie;
    slv_rd_done = 1'b0;
    slv_wr_done = 1'b0;
    if (pend_rsp != 0) begin
      if (dcnt == 0) begin
        pend_rsp = 0;
        if (pend_wr) slv_wr_done = 1'b1; else slv_rd_done = 1'b1;
      end else dcnt--;
    end
    if (m_rd_mem || m_wr_mem) begin
      if (exp_iss.size() == 0) chk("unexp_issue", 1, 0);
      else begin
        ie = exp_iss.pop_front();
        chk("iss_wr", {31'd0, m_wr_mem}, {31'd0, ie.wr});
        chk("iss_rd", {31'd0, m_rd_mem}, {31'd0, !ie.wr});
        chk("iss_addr", {13'd0, m_addr}, {13'd0, ie.addr});
        if (ie.wr) chk("iss_data", {16'd0, m_wr_data}, {16'd0, ie.data});
      end
      if (slv_en != 0) begin
        if (slv_dly == 0) begin
          if (m_wr_mem) slv_wr_done = 1'b1; else slv_rd_done = 1'b1;
        end else begin
          pend_rsp = 1;
          pend_wr  = m_wr_mem;
          dcnt     = slv_dly - 1;
        end
      end
    end
  end

  task automatic chk_done(input logic port, input logic rd, input logic wr,
                          input logic [15:0] data, input logic err);
    done_t e;
    if (exp_done.size() == 0) begin
      chk("unexp_done", 1, 0);
      return;
    end
    e = exp_done.pop_front();
    chk("done_port", {31'd0, port}, {31'd0, e.port});
    chk("done_rd", {31'd0, rd}, {31'd0, e.rd});
    chk("done_wr", {31'd0, wr}, {31'd0, !e.rd});
    if (e.rd) chk("rd_data", {16'd0, data}, {16'd0, e.data});
    chk("err", {31'd0, err}, {31'd0, e.err});
    chk("done_cyc", cyc, e.cyc);
  endtask

  always @(negedge Clk) begin
    if (a_rd_done || a_wr_done) chk_done(1'b0, a_rd_done, a_wr_done, a_rd_data, a_err);
    if (b_rd_done || b_wr_done) chk_done(1'b1, b_rd_done, b_wr_done, b_rd_data, b_err);
  end

  task automatic drv(input logic p, input logic rd, input logic wr,
                     input logic [19:1] ad, input logic [15:0] d);
    if (!p) begin
      a_rd_mem = rd; a_wr_mem = wr; a_addr = ad; a_wr_data = d;
    end else begin
      b_rd_mem = rd; b_wr_mem = wr; b_addr = ad; b_wr_data = d;
    end
  endtask

  task automatic clr_req();
    a_rd_mem = 1'b0; a_wr_mem = 1'b0; b_rd_mem = 1'b0; b_wr_mem = 1'b0;
  endtask

  task automatic push_iss(input logic wr, input logic [19:1] ad, input logic [15:0] wd);
    iss_t ie;
    ie.wr = wr; ie.addr = ad; ie.data = wd;
    exp_iss.push_back(ie);
  endtask

  task automatic exp_acc(input logic p, input logic wr, input logic [19:1] ad, input logic [15:0] wd,
                         input logic [15:0] rdd, input logic err, input int c);
    done_t de;
    push_iss(wr, ad, wd);
    de.port = p; de.rd = !wr; de.data = rdd; de.err = err; de.cyc = c;
    exp_done.push_back(de);
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while ((exp_done.size() != 0 || busy) && k < maxc) begin
      @(negedge Clk);
      k++;
    end
    if (k >= maxc) chk("idle_timeout", 1, 0);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_m_rd", {31'd0, m_rd_mem}, 0);
    chk("rst_m_wr", {31'd0, m_wr_mem}, 0);
    chk("rst_m_addr", {13'd0, m_addr}, 0);
    chk("rst_m_wdata", {16'd0, m_wr_data}, 0);
    chk("rst_a_rdata", {16'd0, a_rd_data}, 0);
    chk("rst_b_rdata", {16'd0, b_rd_data}, 0);
    chk("rst_ovr", {30'd0, a_overrun, b_overrun}, 0);

    // Simultaneous writes after reset: A first, then alternating.
    for (int r = 0; r < 2; r++) begin
      @(negedge Clk); n = cyc;
      drv(1'b0, 1'b0, 1'b1, 19'(16'h100 + r), 16'h5555);
      drv(1'b1, 1'b0, 1'b1, 19'(16'h200 + r), 16'hAAAA);
      exp_acc(1'b0, 1'b1, 19'(16'h100 + r), 16'h5555, 16'h0, 1'b0, n + 4);
      exp_acc(1'b1, 1'b1, 19'(16'h200 + r), 16'hAAAA, 16'h0, 1'b0, n + 7);
      @(negedge Clk); clr_req();
      wait_idle(50);
    end

    // Single read from A, slave answers one cycle after strobe.
    m_rd_data = 16'h1234;
    @(negedge Clk); n = cyc;
    drv(1'b0, 1'b1, 1'b0, 19'h2, 16'h0);
    exp_acc(1'b0, 1'b0, 19'h2, 16'h0, 16'h1234, 1'b0, n + 4);
    @(negedge Clk); clr_req();
    wait_idle(50);
    chk("b_rdata_untouched", {16'd0, b_rd_data}, 0);

    // A went last, so a simultaneous pair now starts with B.
    @(negedge Clk); n = cyc;
    drv(1'b0, 1'b1, 1'b0, 19'h3, 16'h0);
    drv(1'b1, 1'b1, 1'b0, 19'h4, 16'h0);
    exp_acc(1'b1, 1'b0, 19'h4, 16'h0, 16'h1234, 1'b0, n + 4);
    exp_acc(1'b0, 1'b0, 19'h3, 16'h0, 16'h1234, 1'b0, n + 7);
    @(negedge Clk); clr_req();
    wait_idle(50);

    // Done during ISSUE.
    slv_dly = 0;
    @(negedge Clk); n = cyc;
    drv(1'b0, 1'b0, 1'b1, 19'h5, 16'h0F0F);
    exp_acc(1'b0, 1'b1, 19'h5, 16'h0F0F, 16'h0, 1'b0, n + 3);
    @(negedge Clk); clr_req();
    wait_idle(50);
    slv_dly = 1;

    // Strobe on the same edge as that port's done is captured, not an overrun.
    m_rd_data = 16'h1111;
    @(negedge Clk); n = cyc;
    drv(1'b0, 1'b1, 1'b0, 19'h6, 16'h0);
    exp_acc(1'b0, 1'b0, 19'h6, 16'h0, 16'h1111, 1'b0, n + 4);
    exp_acc(1'b0, 1'b0, 19'h7, 16'h0, 16'h1111, 1'b0, n + 7);
    @(negedge Clk); clr_req();
    @(negedge Clk);
    @(negedge Clk); drv(1'b0, 1'b1, 1'b0, 19'h7, 16'h0);
    @(negedge Clk); clr_req();
    wait_idle(50);
    chk("a_ovr_clean", {31'd0, a_overrun}, 0);

    // Second strobe while pending is dropped.
    @(negedge Clk); n = cyc;
    drv(1'b0, 1'b1, 1'b0, 19'h8, 16'h0);
    exp_acc(1'b0, 1'b0, 19'h8, 16'h0, 16'h1111, 1'b0, n + 4);
    @(negedge Clk); drv(1'b0, 1'b1, 1'b0, 19'h9, 16'h0);
    @(negedge Clk); clr_req();
    wait_idle(50);
    chk("a_ovr_set", {31'd0, a_overrun}, 1);
    chk("b_ovr_clear", {31'd0, b_overrun}, 0);

    // rd and wr together: handled as a write, flagged as overrun.
    @(negedge Clk); n = cyc;
    drv(1'b1, 1'b1, 1'b1, 19'hA, 16'hBEEF);
    exp_acc(1'b1, 1'b1, 19'hA, 16'hBEEF, 16'h0, 1'b0, n + 4);
    @(negedge Clk); clr_req();
    wait_idle(50);
    chk("b_ovr_rdwr", {31'd0, b_overrun}, 1);

    // Unanswered read from B times out after 64 WAIT cycles.
    slv_en = 0;
    @(negedge Clk); n = cyc;
    drv(1'b1, 1'b1, 1'b0, 19'hB, 16'h0);
    exp_acc(1'b1, 1'b0, 19'hB, 16'h0, 16'hDEAD, 1'b1, n + 67);
    @(negedge Clk); clr_req();
    wait_idle(200);
    chk("tmo_busy", {31'd0, busy}, 0);

    // Reset while waiting; a late slave done must produce nothing.
    @(negedge Clk); n = cyc;
    drv(1'b0, 1'b1, 1'b0, 19'hC, 16'h0);
    push_iss(1'b0, 19'hC, 16'h0);
    @(negedge Clk); clr_req();
    repeat (3) @(negedge Clk);
    chk("wait_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    @(negedge Clk); rst_n = 1'b1;
    @(negedge Clk); man_rd_done = 1'b1;
    @(negedge Clk); man_rd_done = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_m_addr", {13'd0, m_addr}, 0);
    chk("mid_rst_m_strb", {30'd0, m_rd_mem, m_wr_mem}, 0);
    chk("mid_rst_a_rdata", {16'd0, a_rd_data}, 0);
    chk("mid_rst_b_rdata", {16'd0, b_rd_data}, 0);
    chk("mid_rst_ovr", {30'd0, a_overrun, b_overrun}, 0);

    chk("iss_left", exp_iss.size(), 0);
    chk("done_left", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
